execute_divide_param: RTL and testbench

EXECUTE_DIVIDE_PARAM -- requirements
Module: execute_divide_param

---
 rtl/execute_divide_param_pkg.sv | 25 ++
 rtl/div_clz.sv | 24 ++
 rtl/execute_divide_param.sv | 165 ++++++++++++++++
 tb/tb_execute_divide_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/execute_divide_param_pkg.sv
// execute_divide_param_pkg: shared divider state encodings and special-case constant helpers.
// Rev 1.0 - initial release
`default_nettype none

package execute_divide_param_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_FIX  = 2'd2,
        DIV_ST_DONE = 2'd3
    } div_state_t;

    // Helpers return 64-bit values; callers keep the low WIDTH bits.
    function automatic logic [63:0] div_signed_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] div_signed_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_clz.sv
// div_clz: combinational leading-zero counter; all-zero input yields WIDTH.
// Rev 1.0 - initial release
`default_nettype none

module div_clz #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]               value,
    output logic [$clog2(WIDTH+1)-1:0]     count
);

    localparam int CW = $clog2(WIDTH + 1);

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_divide_param.sv
// execute_divide_param: iterative restoring signed/unsigned divider with overflow handling.
// Optional macro DIV_EARLY_OUT_EN skips leading-zero iterations. Rev 1.0 - initial release
`default_nettype none

module execute_divide_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             unsigned_div,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             ov
);

    import execute_divide_param_pkg::*;

    localparam int               CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    c_width    = CW'(WIDTH);
    localparam logic [63:0]      c_min_full = div_signed_min(WIDTH);
    localparam logic [63:0]      c_max_full = div_signed_max(WIDTH);
    localparam logic [WIDTH-1:0] c_min      = c_min_full[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_max      = c_max_full[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_all_ones = '1;

    div_state_t       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_a_pre;
    logic [CW-1:0]    w_iters;
    logic [WIDTH-1:0] w_zero_q;
    logic             w_ovf;
    logic [WIDTH:0]   w_shift;
    logic             w_take;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;

    assign w_a_neg  = ~unsigned_div & in_a[WIDTH-1];
    assign w_b_neg  = ~unsigned_div & in_b[WIDTH-1];
    // Negating MIN wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? -in_a : in_a;
    assign w_b_mag  = w_b_neg ? -in_b : in_b;
    assign w_zero_q = unsigned_div ? c_all_ones : (in_a[WIDTH-1] ? c_min : c_max);
    assign w_ovf    = ~unsigned_div && (in_a == c_min) && (in_b == c_all_ones);

`ifdef DIV_EARLY_OUT_EN
    logic [CW-1:0] w_lz;
    logic [CW-1:0] w_shamt;

    div_clz #(.WIDTH(WIDTH)) u_clz (
        .value (w_a_mag),
        .count (w_lz)
    );

    assign w_iters = (w_lz == c_width) ? CW'(1) : (c_width - w_lz);
    assign w_shamt = c_width - w_iters;
    assign w_a_pre = w_a_mag << w_shamt;
`else
    assign w_iters = c_width;
    assign w_a_pre = w_a_mag;
`endif

    // Partial remainder is always below the divisor, so the WIDTH-bit difference is exact.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_take     = (w_shift >= {1'b0, r_div});
    assign w_diff     = w_shift[WIDTH-1:0] - r_div;
    assign w_rem_next = w_take ? w_diff : w_shift[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_ST_IDLE;
            done    <= 1'b0;
            busy    <= 1'b0;
            out_q   <= '0;
            out_r   <= '0;
            ov      <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                DIV_ST_IDLE: begin
                    if (enable) begin
                        if (in_b == '0) begin
                            out_q   <= w_zero_q;
                            out_r   <= in_a;
                            ov      <= 1'b1;
                            done    <= 1'b1;
                            r_state <= DIV_ST_DONE;
                        end else if (w_ovf) begin
                            out_q   <= c_max;
                            out_r   <= '0;
                            ov      <= 1'b1;
                            done    <= 1'b1;
                            r_state <= DIV_ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_pre;
                            r_div   <= w_b_mag;
                            r_cnt   <= w_iters;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            busy    <= 1'b1;
                            r_state <= DIV_ST_BUSY;
                        end
                    end
                end
                DIV_ST_BUSY: begin
                    if (!enable) begin
                        busy    <= 1'b0;
                        r_state <= DIV_ST_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[WIDTH-2:0], w_take};
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) r_state <= DIV_ST_FIX;
                    end
                end
                DIV_ST_FIX: begin
                    busy <= 1'b0;
                    if (!enable) begin
                        r_state <= DIV_ST_IDLE;
                    end else begin
                        out_q   <= r_neg_q ? -r_quo : r_quo;
                        out_r   <= r_neg_r ? -r_rem : r_rem;
                        ov      <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DIV_ST_DONE;
                    end
                end
                DIV_ST_DONE: begin
                    if (!enable) begin
                        done    <= 1'b0;
                        r_state <= DIV_ST_IDLE;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= DIV_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_divide_param.sv
// tb_execute_divide_param: table-driven directed checks of execute_divide_param at WIDTH=32.
`default_nettype none

module tb_execute_divide_param;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        unsigned_div;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        done;
    logic        busy;
    logic [31:0] out_q;
    logic [31:0] out_r;
    logic        ov;

    int n_checks = 0;
    int n_fail   = 0;

    execute_divide_param #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .unsigned_div (unsigned_div),
        .in_a         (in_a),
        .in_b         (in_b),
        .done         (done),
        .busy         (busy),
        .out_q        (out_q),
        .out_r        (out_r),
        .ov           (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        ov;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected completion edge, counting the accepting edge as 1.
    function automatic int exp_lat(input logic uns, input logic [31:0] a, input logic [31:0] b);
        int iters;
        logic [31:0] mag;
        if (b == 32'd0) return 1;
        if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        mag   = (!uns && a[31]) ? (32'd0 - a) : a;
        iters = 32;
`ifdef DIV_EARLY_OUT_EN
        iters = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
`else
        if (mag == 32'd0) iters = 32;
`endif
        return iters + 2;
    endfunction

    task automatic run_op(input logic uns, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic eov,
                          input string nm);
        int edges;
        bit got;
        logic [31:0] q_seen;
        @(negedge clk);
        unsigned_div = uns;
        in_a         = a;
        in_b         = b;
        enable       = 1'b1;
        edges        = 0;
        got          = 1'b0;
        while (!got && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) got = 1'b1;
            else if (edges == 1) chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        end
        chk({nm, " done seen"}, {31'd0, got}, 32'd1);
        chk({nm, " latency"}, edges, exp_lat(uns, a, b));
        chk({nm, " q"}, out_q, eq);
        chk({nm, " r"}, out_r, er);
        chk({nm, " ov"}, {31'd0, ov}, {31'd0, eov});
        q_seen = out_q;
        @(posedge clk);
        #1;
        chk({nm, " done held"}, {31'd0, done}, 32'd1);
        chk({nm, " q held"}, out_q, q_seen);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " release done"}, {31'd0, done}, 32'd0);
        chk({nm, " release busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q_prev, r_prev, cancel_a;
        logic        ov_prev;

        vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "u100/7"};
        vecs[1]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, "s-7/2"};
        vecs[2]  = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, "s7/-2"};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFB,  32'd0,          32'h8000_0000,  32'hFFFF_FFFB,  1'b1, "s-5/0"};
        vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, "u5/0"};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'h7FFF_FFFF,  32'd5,          1'b1, "s5/0"};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'd0,          1'b1, "sMIN/-1"};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, "sMIN/1"};
        vecs[8]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, "uMIN/ones"};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          1'b0, "uones/10"};
        vecs[10] = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, "s-100/-7"};
        vecs[11] = '{1'b1, 32'd5,          32'd1,          32'd5,          32'd0,          1'b0, "u5/1"};
        vecs[12] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, "s0/5"};
        vecs[13] = '{1'b1, 32'd3,          32'd7,          32'd0,          32'd3,          1'b0, "u3/7"};

        reset        = 1'b1;
        enable       = 1'b0;
        unsigned_div = 1'b1;
        in_a         = 32'd0;
        in_b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset q", out_q, 32'd0);
        chk("reset r", out_r, 32'd0);
        chk("reset ov", {31'd0, ov}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].ov, vecs[i].name);
        end

        // Cancel: enable low at edge 10 of a long unsigned division.
`ifdef DIV_EARLY_OUT_EN
        cancel_a = 32'h8000_0064;
`else
        cancel_a = 32'd100;
`endif
        q_prev  = out_q;
        r_prev  = out_r;
        ov_prev = ov;
        @(negedge clk);
        unsigned_div = 1'b1;
        in_a         = cancel_a;
        in_b         = 32'd7;
        enable       = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("cancel busy before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        chk("cancel done", {31'd0, done}, 32'd0);
        chk("cancel q", out_q, q_prev);
        chk("cancel r", out_r, r_prev);
        chk("cancel ov", {31'd0, ov}, {31'd0, ov_prev});
        run_op(1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "after cancel 9/3");

        // Reset at edge 2 of an in-flight division.
        @(negedge clk);
        unsigned_div = 1'b0;
        in_a         = 32'd1000;
        in_b         = 32'd3;
        enable       = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset q", out_q, 32'd0);
        chk("midreset r", out_r, 32'd0);
        @(posedge clk);
        #1;
        chk("reset blocks accept", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset done", {31'd0, done}, 32'd0);
        run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "after reset 1000/3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
